// File: rtl/mouse_bus_bridge.sv
// ---------------------------------------------------------------------------
// mouse_bus_bridge
// Bus peripheral that sits between the PS/2 mouse transceiver and the
// processor bus. Complete mouse packets {status, X, Y} are queued in a small
// FIFO. Each accepted packet raises a level interrupt to the processor. The
// ISR reads the head packet through the register window and pops it by
// writing the status/control register.
//
// Register window (offsets from BASE_ADDR):
//   +0  read : head status byte (00 when empty)
//   +1  read : head X byte      (00 when empty)
//   +2  read : head Y byte      (00 when empty)
//   +3  read : {OVF, 4'b0000, COUNT[2:0]}
//       write: pop head if non-empty; data[7]=1 also clears OVF
//   +4  read : drop counter, write: clear drop counter
//       (only present when MOUSE_BRIDGE_OVF_CNT_EN is defined; otherwise
//        the address is unmapped and the bus is never driven for it)
//
// Optional feature macro: MOUSE_BRIDGE_OVF_CNT_EN
// ---------------------------------------------------------------------------
module mouse_bus_bridge #(
    parameter logic [7:0] BASE_ADDR = 8'hA0,
    parameter int         FIFO_AW   = 2
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [7:0] MOUSE_STATUS,
    input  logic [7:0] MOUSE_X,
    input  logic [7:0] MOUSE_Y,
    input  logic       MOUSE_SEND_INTERRUPT,
    inout  wire  [7:0] BUS_DATA,
    input  logic [7:0] BUS_ADDR,
    input  logic       BUS_WE,
    output logic       BUS_INTERRUPT_RAISE,
    input  logic       BUS_INTERRUPT_ACK
);

    localparam int               DEPTH      = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] FULL_COUNT = (FIFO_AW + 1)'(DEPTH);

    localparam logic [7:0] OFF_STATUS = 8'd0;
    localparam logic [7:0] OFF_X      = 8'd1;
    localparam logic [7:0] OFF_Y      = 8'd2;
    localparam logic [7:0] OFF_CTRL   = 8'd3;
`ifdef MOUSE_BRIDGE_OVF_CNT_EN
    localparam logic [7:0] OFF_DROPS  = 8'd4;
    localparam logic [7:0] NUM_REGS   = 8'd5;
`else
    localparam logic [7:0] NUM_REGS   = 8'd4;
`endif

    // Packet storage and bookkeeping
    logic [23:0]        r_fifoMem [DEPTH];
    logic [FIFO_AW-1:0] r_wrPtr;
    logic [FIFO_AW-1:0] r_rdPtr;
    logic [FIFO_AW:0]   r_count;
    logic               r_ovf;
    logic               r_raise;

    // Bus read path
    logic [7:0]         r_readData;
    logic               r_driveEn;

`ifdef MOUSE_BRIDGE_OVF_CNT_EN
    logic [7:0]         r_dropCnt;
`endif

    // Decode and datapath wires
    logic [7:0]         w_offset;
    logic               w_mapped;
    logic               w_popReq;
    logic               w_ovfClear;
    logic               w_empty;
    logic               w_full;
    logic               w_pop;
    logic               w_pushAccept;
    logic               w_pushDrop;
    logic [23:0]        w_head;
    logic [23:0]        w_newPacket;
    logic [7:0]         w_statusByte;
    logic [7:0]         w_readMux;
`ifdef MOUSE_BRIDGE_OVF_CNT_EN
    logic               w_dropClear;
`endif

    // The offset is computed with 8-bit wraparound, so addresses below the
    // base land far above NUM_REGS and decode as unmapped.
    assign w_offset     = BUS_ADDR - BASE_ADDR;
    assign w_mapped     = (w_offset < NUM_REGS);

    assign w_popReq     = BUS_WE && (w_offset == OFF_CTRL);
    assign w_ovfClear   = w_popReq && ((BUS_DATA & 8'h80) != 8'h00);

    assign w_empty      = (r_count == '0);
    assign w_full       = (r_count == FULL_COUNT);
    assign w_pop        = w_popReq && !w_empty;

    // A pop in the same cycle frees the slot, so a push into a full FIFO
    // is still accepted when the processor is popping at the same time.
    assign w_pushAccept = MOUSE_SEND_INTERRUPT && (!w_full || w_pop);
    assign w_pushDrop   = MOUSE_SEND_INTERRUPT && !w_pushAccept;

    assign w_newPacket  = {MOUSE_STATUS, MOUSE_X, MOUSE_Y};

    // Head is taken straight from the read pointer so that a read issued
    // the cycle after a pop already sees the next packet.
    assign w_head       = w_empty ? 24'h000000 : r_fifoMem[r_rdPtr];
    assign w_statusByte = {r_ovf, 4'b0000, 3'(r_count)};

`ifdef MOUSE_BRIDGE_OVF_CNT_EN
    assign w_dropClear  = BUS_WE && (w_offset == OFF_DROPS);
`endif

    // Select the register value that a bus read at the current address returns
    always_comb begin
        w_readMux = 8'h00;
        case (w_offset)
            OFF_STATUS: w_readMux = w_head[23:16];
            OFF_X:      w_readMux = w_head[15:8];
            OFF_Y:      w_readMux = w_head[7:0];
            OFF_CTRL:   w_readMux = w_statusByte;
`ifdef MOUSE_BRIDGE_OVF_CNT_EN
            OFF_DROPS:  w_readMux = r_dropCnt;
`endif
            default:    w_readMux = 8'h00;
        endcase
    end

    // Packet storage; contents need no reset because the head is masked while empty
    always_ff @(posedge CLK) begin
        if (!RESET && w_pushAccept) begin
            r_fifoMem[r_wrPtr] <= w_newPacket;
        end
    end

    // Write/read pointers and occupancy count
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_pushAccept) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            case ({w_pushAccept, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky overflow flag: set by a dropped push, cleared by software
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_ovf <= 1'b0;
        end else if (w_pushDrop) begin
            r_ovf <= 1'b1;
        end else if (w_ovfClear) begin
            r_ovf <= 1'b0;
        end
    end

    // Interrupt request: a new accepted packet outranks an acknowledge
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_raise <= 1'b0;
        end else if (w_pushAccept) begin
            r_raise <= 1'b1;
        end else if (BUS_INTERRUPT_ACK) begin
            r_raise <= 1'b0;
        end
    end

    // Registered bus read: capture the value and hold the bus until the master moves on
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_readData <= 8'h00;
            r_driveEn  <= 1'b0;
        end else if (!BUS_WE && w_mapped) begin
            r_readData <= w_readMux;
            r_driveEn  <= 1'b1;
        end else begin
            r_driveEn  <= 1'b0;
        end
    end

`ifdef MOUSE_BRIDGE_OVF_CNT_EN
    // Saturating count of dropped packets; a software clear takes priority
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_dropCnt <= 8'h00;
        end else if (w_dropClear) begin
            r_dropCnt <= 8'h00;
        end else if (w_pushDrop && (r_dropCnt != 8'hFF)) begin
            r_dropCnt <= r_dropCnt + 8'd1;
        end
    end
`endif

    assign BUS_DATA            = r_driveEn ? r_readData : 8'hzz;
    assign BUS_INTERRUPT_RAISE = r_raise;

endmodule

// File: tb/tb_mouse_bus_bridge.sv
// ---------------------------------------------------------------------------
// tb_mouse_bus_bridge
// Directed vector table for the documented scenarios followed by randomized
// traffic compared against a queue-based reference model. The bus has a
// pull-up, so an undriven bus reads 8'hFF.
// Honours MOUSE_BRIDGE_OVF_CNT_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_mouse_bus_bridge;

    localparam logic [7:0] A0 = 8'hA0;
    localparam logic [7:0] A1 = 8'hA1;
    localparam logic [7:0] A2 = 8'hA2;
    localparam logic [7:0] A3 = 8'hA3;
    localparam logic [7:0] A4 = 8'hA4;
    localparam logic [7:0] IDLE_ADDR = 8'h00;
    localparam logic [7:0] BUS_IDLE  = 8'hFF;

`ifdef MOUSE_BRIDGE_OVF_CNT_EN
    localparam logic [7:0] EXP_A4_DROPS = 8'h03;
    localparam logic [7:0] EXP_A4_CLR   = 8'h00;
`else
    localparam logic [7:0] EXP_A4_DROPS = BUS_IDLE;
    localparam logic [7:0] EXP_A4_CLR   = BUS_IDLE;
`endif

    logic        CLK = 1'b0;
    logic        RESET;
    logic [7:0]  MOUSE_STATUS;
    logic [7:0]  MOUSE_X;
    logic [7:0]  MOUSE_Y;
    logic        MOUSE_SEND_INTERRUPT;
    wire  [7:0]  busData;
    logic [7:0]  BUS_ADDR;
    logic        BUS_WE;
    logic        BUS_INTERRUPT_RAISE;
    logic        BUS_INTERRUPT_ACK;
    logic        tbDrive;
    logic [7:0]  tbData;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        rst;
        logic        we;
        logic [7:0]  addr;
        logic [7:0]  wdata;
        logic        push;
        logic [23:0] pkt;
        logic        ack;
        logic        chkBus;
        logic [7:0]  expBus;
        logic        expRaise;
    } vec_t;

    vec_t vecs[$];

    // Reference model state
    logic [23:0] mq[$];
    logic        mOvf;
    logic        mRaise;
    logic        mDrive;
    logic [7:0]  mRead;
    logic [7:0]  mDrops;

    assign busData = tbDrive ? tbData : 8'hzz;

    for (genvar g = 0; g < 8; g++) begin : g_pull
        pullup (busData[g]);
    end

    always #5 CLK = ~CLK;

    mouse_bus_bridge dut (
        .CLK                  (CLK),
        .RESET                (RESET),
        .MOUSE_STATUS         (MOUSE_STATUS),
        .MOUSE_X              (MOUSE_X),
        .MOUSE_Y              (MOUSE_Y),
        .MOUSE_SEND_INTERRUPT (MOUSE_SEND_INTERRUPT),
        .BUS_DATA             (busData),
        .BUS_ADDR             (BUS_ADDR),
        .BUS_WE               (BUS_WE),
        .BUS_INTERRUPT_RAISE  (BUS_INTERRUPT_RAISE),
        .BUS_INTERRUPT_ACK    (BUS_INTERRUPT_ACK)
    );

    function automatic vec_t mk(logic rst, logic we, logic [7:0] addr, logic [7:0] wdata,
                                logic push, logic [23:0] pkt, logic ack,
                                logic chkBus, logic [7:0] expBus, logic expRaise);
        vec_t v;
        v.rst = rst; v.we = we; v.addr = addr; v.wdata = wdata;
        v.push = push; v.pkt = pkt; v.ack = ack;
        v.chkBus = chkBus; v.expBus = expBus; v.expRaise = expRaise;
        return v;
    endfunction

    function automatic vec_t rIdle(logic r);
        return mk(1'b0, 1'b0, IDLE_ADDR, 8'h00, 1'b0, 24'h0, 1'b0, 1'b1, BUS_IDLE, r);
    endfunction

    function automatic vec_t rRead(logic [7:0] a, logic [7:0] e, logic r);
        return mk(1'b0, 1'b0, a, 8'h00, 1'b0, 24'h0, 1'b0, 1'b1, e, r);
    endfunction

    function automatic vec_t rWrite(logic [7:0] a, logic [7:0] d, logic r);
        return mk(1'b0, 1'b1, a, d, 1'b0, 24'h0, 1'b0, 1'b0, 8'h00, r);
    endfunction

    function automatic vec_t rPush(logic [23:0] p, logic r);
        return mk(1'b0, 1'b0, IDLE_ADDR, 8'h00, 1'b1, p, 1'b0, 1'b1, BUS_IDLE, r);
    endfunction

    function automatic vec_t rAck(logic r);
        return mk(1'b0, 1'b0, IDLE_ADDR, 8'h00, 1'b0, 24'h0, 1'b1, 1'b1, BUS_IDLE, r);
    endfunction

    function automatic vec_t rReset();
        return mk(1'b1, 1'b0, IDLE_ADDR, 8'h00, 1'b0, 24'h0, 1'b0, 1'b1, BUS_IDLE, 1'b0);
    endfunction

    // Drive one cycle of inputs at a falling edge and wait for the next falling edge
    task automatic applyStimulus(input vec_t v);
        RESET                = v.rst;
        BUS_WE               = v.we;
        BUS_ADDR             = v.addr;
        tbDrive              = v.we;
        tbData               = v.wdata;
        MOUSE_SEND_INTERRUPT = v.push;
        {MOUSE_STATUS, MOUSE_X, MOUSE_Y} = v.pkt;
        BUS_INTERRUPT_ACK    = v.ack;
        @(negedge CLK);
    endtask

    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %02h, expected %02h", name, actual, expected);
        end
    endtask

    function automatic logic modelMapped(logic [7:0] addr);
`ifdef MOUSE_BRIDGE_OVF_CNT_EN
        return (addr >= A0) && (addr <= A4);
`else
        return (addr >= A0) && (addr <= A3);
`endif
    endfunction

    function automatic logic [7:0] modelReg(logic [7:0] addr);
        logic [23:0] head;
        int          n;
        n    = mq.size();
        head = (n == 0) ? 24'h0 : mq[0];
        case (addr)
            A0:      return head[23:16];
            A1:      return head[15:8];
            A2:      return head[7:0];
            A3:      return {mOvf, 4'b0000, 3'(n)};
            default: return mDrops;
        endcase
    endfunction

    // One clock edge of the packet queue as a processor would see it
    task automatic modelStep(input vec_t v);
        logic accepted;
        if (v.rst) begin
            mq.delete();
            mOvf = 1'b0; mRaise = 1'b0; mDrive = 1'b0; mRead = 8'h00; mDrops = 8'h00;
            return;
        end
        if (!v.we && modelMapped(v.addr)) begin
            mRead  = modelReg(v.addr);
            mDrive = 1'b1;
        end else begin
            mDrive = 1'b0;
        end
        if (v.we && v.addr == A3 && mq.size() > 0) begin
            void'(mq.pop_front());
        end
        if (v.we && v.addr == A3 && v.wdata[7]) begin
            mOvf = 1'b0;
        end
        accepted = 1'b0;
        if (v.push) begin
            if (mq.size() < 4) begin
                mq.push_back(v.pkt);
                accepted = 1'b1;
            end else begin
                mOvf = 1'b1;
`ifdef MOUSE_BRIDGE_OVF_CNT_EN
                if (!(v.we && v.addr == A4) && mDrops != 8'hFF) mDrops = mDrops + 8'd1;
`endif
            end
        end
`ifdef MOUSE_BRIDGE_OVF_CNT_EN
        if (v.we && v.addr == A4) mDrops = 8'h00;
`endif
        if (accepted) mRaise = 1'b1;
        else if (v.ack) mRaise = 1'b0;
    endtask

    initial begin
        logic [7:0] rdAddrs [8];
        logic [7:0] wrAddrs [4];
        vec_t       v;
        int         op;

        rdAddrs = '{A0, A1, A2, A3, A4, IDLE_ADDR, 8'h9F, 8'hA5};
        wrAddrs = '{A3, A3, A4, A0};

        // Reset and first packet readback
        vecs.push_back(rReset());
        vecs.push_back(rReset());
        vecs.push_back(rRead(A3, 8'h00, 1'b0));
        vecs.push_back(rIdle(1'b0));
        vecs.push_back(rPush(24'h0805FB, 1'b1));
        vecs.push_back(rRead(A0, 8'h08, 1'b1));
        vecs.push_back(rRead(A1, 8'h05, 1'b1));
        vecs.push_back(rRead(A2, 8'hFB, 1'b1));
        vecs.push_back(rRead(A3, 8'h01, 1'b1));
        vecs.push_back(rAck(1'b0));
        vecs.push_back(rIdle(1'b0));
        // Overflow on the fifth packet, then pop with OVF clear
        vecs.push_back(rReset());
        vecs.push_back(rIdle(1'b0));
        vecs.push_back(rPush(24'h110102, 1'b1));
        vecs.push_back(rPush(24'h120304, 1'b1));
        vecs.push_back(rPush(24'h130506, 1'b1));
        vecs.push_back(rPush(24'h140708, 1'b1));
        vecs.push_back(rPush(24'h15090A, 1'b1));
        vecs.push_back(rRead(A3, 8'h84, 1'b1));
        vecs.push_back(rRead(A0, 8'h11, 1'b1));
        vecs.push_back(rRead(A1, 8'h01, 1'b1));
        vecs.push_back(rIdle(1'b1));
        vecs.push_back(rWrite(A3, 8'h80, 1'b1));
        vecs.push_back(rRead(A3, 8'h03, 1'b1));
        vecs.push_back(rRead(A0, 8'h12, 1'b1));
        vecs.push_back(rAck(1'b0));
        // Push and pop together while full
        vecs.push_back(rPush(24'h160B0C, 1'b1));
        vecs.push_back(rRead(A3, 8'h04, 1'b1));
        vecs.push_back(rIdle(1'b1));
        vecs.push_back(mk(1'b0, 1'b1, A3, 8'h00, 1'b1, 24'h170D0E, 1'b0, 1'b0, 8'h00, 1'b1));
        vecs.push_back(rRead(A3, 8'h04, 1'b1));
        vecs.push_back(rRead(A0, 8'h13, 1'b1));
        vecs.push_back(rIdle(1'b1));
        vecs.push_back(rWrite(A3, 8'h00, 1'b1));
        vecs.push_back(rWrite(A3, 8'h00, 1'b1));
        vecs.push_back(rWrite(A3, 8'h00, 1'b1));
        vecs.push_back(rRead(A0, 8'h17, 1'b1));
        vecs.push_back(rRead(A1, 8'h0D, 1'b1));
        vecs.push_back(rRead(A2, 8'h0E, 1'b1));
        vecs.push_back(rRead(A3, 8'h01, 1'b1));
        // ACK colliding with a push, then pop on empty
        vecs.push_back(rAck(1'b0));
        vecs.push_back(mk(1'b0, 1'b0, IDLE_ADDR, 8'h00, 1'b1, 24'h180000, 1'b1, 1'b1, BUS_IDLE, 1'b1));
        vecs.push_back(rIdle(1'b1));
        vecs.push_back(rWrite(A3, 8'h00, 1'b1));
        vecs.push_back(rWrite(A3, 8'h00, 1'b1));
        vecs.push_back(rWrite(A3, 8'h00, 1'b1));
        vecs.push_back(rRead(A3, 8'h00, 1'b1));
        vecs.push_back(rRead(A0, 8'h00, 1'b1));
        vecs.push_back(rIdle(1'b1));
        // Three drops and the optional drop counter
        vecs.push_back(rReset());
        vecs.push_back(rIdle(1'b0));
        for (int i = 0; i < 7; i++) begin
            vecs.push_back(rPush({8'h20 + 8'(i), 16'h0000}, 1'b1));
        end
        vecs.push_back(rRead(A3, 8'h84, 1'b1));
        vecs.push_back(rRead(A4, EXP_A4_DROPS, 1'b1));
        vecs.push_back(rIdle(1'b1));
        vecs.push_back(rWrite(A4, 8'h00, 1'b1));
        vecs.push_back(rRead(A4, EXP_A4_CLR, 1'b1));
        vecs.push_back(rRead(A3, 8'h84, 1'b1));
        vecs.push_back(rIdle(1'b1));
        // Reset while holding packets discards them
        vecs.push_back(rReset());
        vecs.push_back(rRead(A3, 8'h00, 1'b0));
        vecs.push_back(rRead(A0, 8'h00, 1'b0));

        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            if (vecs[i].chkBus) begin
                checkOutput($sformatf("vec%0d bus", i), busData, vecs[i].expBus);
            end
            checkOutput($sformatf("vec%0d raise", i), {7'b0, BUS_INTERRUPT_RAISE}, {7'b0, vecs[i].expRaise});
        end

        // Randomized traffic against the reference model
        v = rReset();
        applyStimulus(v);
        modelStep(v);
        for (int c = 0; c < 600; c++) begin
            v = rIdle(1'b0);
            op = $urandom_range(0, 9);
            if (op <= 4) begin
                v.addr = rdAddrs[$urandom_range(0, 7)];
            end else if (op <= 7 && !mDrive) begin
                v.we    = 1'b1;
                v.addr  = wrAddrs[$urandom_range(0, 3)];
                v.wdata = 8'($urandom);
            end
            v.push = ($urandom_range(0, 2) == 0);
            v.pkt  = 24'($urandom);
            v.ack  = ($urandom_range(0, 3) == 0);
            applyStimulus(v);
            modelStep(v);
            if (!v.we) begin
                checkOutput($sformatf("rand%0d bus", c), busData, mDrive ? mRead : BUS_IDLE);
            end
            checkOutput($sformatf("rand%0d raise", c), {7'b0, BUS_INTERRUPT_RAISE}, {7'b0, mRaise});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
